fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the byte-addressed instruction memory. Holds the program counter, drives the memory read address, captures the combinationally returned 32-bit word into a 2-entry prefetch queue, and presents instructions to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and reload the PC.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Constants and types shared by the RV32I fetch stage.
//               FETCH_MISALIGN_EN adds the misalign flag to fetch_entry_t.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h00000013;  // addi x0, x0, 0
    localparam int          IMEM_ADDR_W   = 7;
    localparam int          FETCH_Q_DEPTH = 2;

    // Queue entry as seen at the default memory address width.
    typedef struct packed {
        logic [31:0]            instr;
        logic [IMEM_ADDR_W-1:0] pc;
`ifdef FETCH_MISALIGN_EN
        logic                   misalign;
`endif
    } fetch_entry_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Two-entry synchronous FIFO holding fetched instructions.
//               Supports flush, simultaneous push/pop while full, and
//               exposes the head entry combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int ENTRY_W = 39
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head_data,
    output logic               o_valid,
    output logic [1:0]         o_count
);

    localparam logic [1:0] c_FULL = 2'd2;

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    // A push while full is only legal when the head leaves on the same edge;
    // in that case the write slot equals the slot being vacated.
    assign w_push_ok = i_push && ((r_count != c_FULL) || w_pop_ok);
    assign w_pop_ok  = i_pop && (r_count != 2'd0);

    // Pointer and occupancy tracking; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_valid     = (r_count != 2'd0);
    assign o_count     = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction fetch stage. Holds the PC, reads the
//               combinational instruction memory, buffers words in a
//               2-entry queue and hands them to decode via valid/ready.
//               Redirects flush the queue and reload the PC.
//               Optional macro: FETCH_MISALIGN_EN (misaligned redirect
//               produces one flagged NOP entry, then fetch halts).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int                ADDR_W   = IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] o_addr_imem,
    input  logic [31:0]       i_data_imem,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic              o_misalign
`endif
);

`ifdef FETCH_MISALIGN_EN
    localparam int c_ENTRY_W = 32 + ADDR_W + 1;
`else
    localparam int c_ENTRY_W = 32 + ADDR_W;
`endif
    localparam logic [1:0]        c_Q_DEPTH = 2'(FETCH_Q_DEPTH);
    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [ADDR_W-1:0]    w_target;
    logic                 w_pop;
    logic                 w_room;
    logic                 w_fetch;
    logic                 w_push;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;
    logic                 w_head_valid;
    logic [1:0]           w_count;
    logic [31:0]          w_head_instr;
    logic [ADDR_W-1:0]    w_head_pc;

    assign w_pop  = w_head_valid && i_instr_ready;
    assign w_room = (w_count < c_Q_DEPTH) || w_pop;

`ifdef FETCH_MISALIGN_EN
    localparam logic [1:0] c_ST_RUN  = 2'd0;  // normal sequential fetch
    localparam logic [1:0] c_ST_PEND = 2'd1;  // enqueue flagged NOP next edge
    localparam logic [1:0] c_ST_HALT = 2'd2;  // wait for the next redirect

    logic [1:0] r_mis_state;
    logic [1:0] w_mis_state_nxt;
    logic       w_push_mis;

    // Misalign sequencing: a misaligned target yields one flagged entry.
    always_comb begin
        w_mis_state_nxt = r_mis_state;
        if (i_redirect) begin
            w_mis_state_nxt = (i_redirect_pc[1:0] != 2'b00) ? c_ST_PEND : c_ST_RUN;
        end else if (r_mis_state == c_ST_PEND) begin
            w_mis_state_nxt = c_ST_HALT;
        end
    end

    // Misalign state register.
    always_ff @(posedge clk) begin
        if (rst) r_mis_state <= c_ST_RUN;
        else     r_mis_state <= w_mis_state_nxt;
    end

    // The queue was flushed by the redirect, so the flagged entry always fits.
    assign w_fetch      = !i_redirect && (r_mis_state == c_ST_RUN) && w_room;
    assign w_push_mis   = !i_redirect && (r_mis_state == c_ST_PEND);
    assign w_push       = w_fetch || w_push_mis;
    assign w_push_entry = w_push_mis ? {NOP_INSTR, r_pc, 1'b1}
                                     : {i_data_imem, r_pc, 1'b0};
    assign w_target     = i_redirect_pc;
    assign o_misalign   = w_head_valid && w_head_entry[0];
`else
    logic w_unused_redirect_lsb;

    // Targets are forced word-aligned; the low bits carry no information.
    assign w_unused_redirect_lsb = ^i_redirect_pc[1:0];
    assign w_fetch      = !i_redirect && w_room;
    assign w_push       = w_fetch;
    assign w_push_entry = {i_data_imem, r_pc};
    assign w_target     = {i_redirect_pc[ADDR_W-1:2], 2'b00};
`endif

    // Next PC: redirect wins, otherwise advance only on an actual fetch.
    always_comb begin
        w_pc_nxt = r_pc;
        if (i_redirect)   w_pc_nxt = w_target;
        else if (w_fetch) w_pc_nxt = r_pc + c_PC_STEP;
    end

    // Program counter register; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_nxt;
    end

    fetch_queue #(
        .ENTRY_W (c_ENTRY_W)
    ) u_fetch_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head_data (w_head_entry),
        .o_valid     (w_head_valid),
        .o_count     (w_count)
    );

    assign w_head_instr  = w_head_entry[c_ENTRY_W-1 -: 32];
    assign w_head_pc     = w_head_entry[c_ENTRY_W-33 -: ADDR_W];

    assign o_addr_imem   = r_pc;
    assign o_instr_valid = w_head_valid;
    assign o_instr       = w_head_valid ? w_head_instr : NOP_INSTR;
    assign o_pc          = w_head_valid ? w_head_pc : r_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Memory word at
//               byte address a holds 32'hC0DE0000 + a.
//               Optional macro: FETCH_MISALIGN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          c_ADDR_W = 7;
    localparam logic [31:0] c_NOP    = 32'h00000013;

    logic                clk;
    logic                rst;
    logic [c_ADDR_W-1:0] o_addr_imem;
    logic [31:0]         i_data_imem;
    logic                o_instr_valid;
    logic                i_instr_ready;
    logic [31:0]         o_instr;
    logic [c_ADDR_W-1:0] o_pc;
    logic                i_redirect;
    logic [c_ADDR_W-1:0] i_redirect_pc;
`ifdef FETCH_MISALIGN_EN
    logic                o_misalign;
`endif

    logic [31:0] imem [32];
    int          n_assert;
    int          n_fail;

    fetch_unit #(
        .ADDR_W   (c_ADDR_W),
        .RESET_PC ('0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_addr_imem   (o_addr_imem),
        .i_data_imem   (i_data_imem),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .o_misalign    (o_misalign)
`endif
    );

    assign i_data_imem = imem[o_addr_imem[6:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input int a);
        return 32'hC0DE0000 + 32'(a);
    endfunction

    // Advance one edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Head of a valid cycle: valid, pc and instruction from memory.
    task automatic chk_head(input string tag, input int pc);
        chk({tag, "_valid"}, 32'(o_instr_valid), 32'd1);
        chk({tag, "_pc"},    32'(o_pc),          32'(pc));
        chk({tag, "_instr"}, o_instr,            wd(pc));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) imem[i] = wd(i * 4);
        rst = 1'b1; i_instr_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;

        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_instr", o_instr,            c_NOP);
        chk("rst_pc",    32'(o_pc),          32'd0);
        chk("rst_addr",  32'(o_addr_imem),   32'd0);

        // Streaming with ready high: first valid one cycle after release
        rst = 1'b0;
        tick(); chk_head("s0", 0);
        tick(); chk_head("s1", 4);
        tick(); chk_head("s2", 8);
        tick(); chk_head("s3", 12);

        // Stall: restart from reset, ready low for 5 cycles after first valid
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); chk_head("st_first", 0);
        i_instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("st_addr",  32'(o_addr_imem), 32'd8);
            chk_head("st_hold", 0);
        end
        i_instr_ready = 1'b1;
        chk_head("bb0", 0);
        tick(); chk_head("bb1", 4);
        tick(); chk_head("bb2", 8);

        // Fill queue (head 8, next 12), then redirect while full
        i_instr_ready = 1'b0;
        tick(); tick();
        chk("full_addr", 32'(o_addr_imem), 32'd16);
        chk_head("full_head", 8);
        i_instr_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 7'h40;
        tick();
        i_redirect = 1'b0;
        chk("rd_bubble_valid", 32'(o_instr_valid), 32'd0);
        chk("rd_bubble_addr",  32'(o_addr_imem),   32'h40);
        tick(); chk_head("rd_t0", 'h40);
        tick(); chk_head("rd_t1", 'h44);

        // PC wrap modulo 128
        i_redirect = 1'b1; i_redirect_pc = 7'd120;
        tick();
        i_redirect = 1'b0;
        chk("wr_bubble_valid", 32'(o_instr_valid), 32'd0);
        tick(); chk_head("wr0", 120);
        tick(); chk_head("wr1", 124);
        tick(); chk_head("wr2", 0);
        tick(); chk_head("wr3", 4);

        // Reset with a full queue and a pending redirect
        i_instr_ready = 1'b0;
        tick(); tick();
        chk("pre_rst_valid", 32'(o_instr_valid), 32'd1);
        rst = 1'b1; i_redirect = 1'b1; i_redirect_pc = 7'h20;
        tick();
        chk("mr_valid", 32'(o_instr_valid), 32'd0);
        chk("mr_addr",  32'(o_addr_imem),   32'd0);
        chk("mr_instr", o_instr,            c_NOP);
        chk("mr_pc",    32'(o_pc),          32'd0);
        rst = 1'b0; i_redirect = 1'b0;
        tick(); chk_head("mr_resume", 0);

        // Misaligned redirect to 0x42
        i_instr_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 7'h42;
        tick();
        i_redirect = 1'b0;
        chk("ma_bubble_valid", 32'(o_instr_valid), 32'd0);
`ifdef FETCH_MISALIGN_EN
        chk("ma_bubble_addr", 32'(o_addr_imem), 32'h42);
        tick();
        chk("ma_valid", 32'(o_instr_valid), 32'd1);
        chk("ma_pc",    32'(o_pc),          32'h42);
        chk("ma_instr", o_instr,            c_NOP);
        chk("ma_flag",  32'(o_misalign),    32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ma_halt_valid", 32'(o_instr_valid), 32'd0);
            chk("ma_halt_flag",  32'(o_misalign),    32'd0);
            chk("ma_halt_addr",  32'(o_addr_imem),   32'h42);
        end
        i_redirect = 1'b1; i_redirect_pc = 7'h10;
        tick();
        i_redirect = 1'b0;
        chk("ma_re_bubble", 32'(o_instr_valid), 32'd0);
        tick(); chk_head("ma_re0", 'h10);
        chk("ma_re0_flag", 32'(o_misalign), 32'd0);
        tick(); chk_head("ma_re1", 'h14);
`else
        chk("ma_bubble_addr", 32'(o_addr_imem), 32'h40);
        tick(); chk_head("ma0", 'h40);
        tick(); chk_head("ma1", 'h44);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_unit
`default_nettype wire
